// File: rtl/rv32_wb_arbiter.sv
// Round-robin writeback arbiter for the single register-file write port, plus a pending-write scoreboard.
// Optional same-cycle forwarding of the in-flight write is enabled by defining RV32_WB_BYPASS_EN.
module rv32_wb_arbiter #(
    parameter int NREQ = 3,
    parameter int XLEN = 32,
    parameter int AW   = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*AW-1:0]   req_wa,
    input  logic [NREQ*XLEN-1:0] req_wd,
    output logic                 rf_wen,
    output logic [AW-1:0]        rf_wa,
    output logic [XLEN-1:0]      rf_wd,
    input  logic                 sb_set,
    input  logic [AW-1:0]        sb_set_addr,
    input  logic [AW-1:0]        q_ra1,
    input  logic [AW-1:0]        q_ra2,
    output logic                 q_busy1,
    output logic                 q_busy2
`ifdef RV32_WB_BYPASS_EN
    ,
    output logic                 q_fwd1,
    output logic                 q_fwd2,
    output logic [XLEN-1:0]      q_fwd_data
`endif
);

    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int NREG = 1 << AW;

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   gnt_idx;
    logic [PW:0]     cand;
    logic            gnt_any;
    logic            xfer;
    logic [AW-1:0]   sel_wa;
    logic [XLEN-1:0] sel_wd;
    logic [NREG-1:0] sb;
    logic [NREG-1:0] sb_next;

    // Rotating priority: walk upward from ptr, wrapping at NREQ.
    always_comb begin
        cand    = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + (PW+1)'(k);
            if (cand >= (PW+1)'(NREQ)) begin
                cand = cand - (PW+1)'(NREQ);
            end
            if (!gnt_any && req_valid[cand[PW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_idx = cand[PW-1:0];
            end
        end
    end

    assign xfer   = gnt_any & rst_n;
    assign sel_wa = req_wa[int'(gnt_idx)*AW +: AW];
    assign sel_wd = req_wd[int'(gnt_idx)*XLEN +: XLEN];

    always_comb begin
        req_ready = '0;
        if (xfer) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_wen <= 1'b0;
            rf_wa  <= '0;
            rf_wd  <= '0;
            ptr    <= '0;
        end else if (xfer) begin
            rf_wen <= (sel_wa != '0);
            rf_wa  <= sel_wa;
            rf_wd  <= sel_wd;
            ptr    <= (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
        end else begin
            rf_wen <= 1'b0;
        end
    end

    // Set is applied after clear so a newly issued producer keeps the register busy.
    always_comb begin
        sb_next = sb;
        if (rf_wen) begin
            sb_next[rf_wa] = 1'b0;
        end
        if (sb_set) begin
            sb_next[sb_set_addr] = 1'b1;
        end
        sb_next[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb <= '0;
        end else begin
            sb <= sb_next;
        end
    end

`ifdef RV32_WB_BYPASS_EN
    assign q_fwd1     = rf_wen && (rf_wa == q_ra1) && (q_ra1 != '0);
    assign q_fwd2     = rf_wen && (rf_wa == q_ra2) && (q_ra2 != '0);
    assign q_fwd_data = rf_wd;
    assign q_busy1    = sb[q_ra1] & ~q_fwd1;
    assign q_busy2    = sb[q_ra2] & ~q_fwd2;
`else
    assign q_busy1    = sb[q_ra1];
    assign q_busy2    = sb[q_ra2];
`endif

endmodule

// File: tb/tb_rv32_wb_arbiter.sv
// Directed bench for rv32_wb_arbiter: expected RF writes are queued at accept time and popped one cycle later.
// Also exercises the forwarding outputs when built with RV32_WB_BYPASS_EN.
module tb_rv32_wb_arbiter;

    localparam int NREQ = 3;
    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*AW-1:0]   req_wa;
    logic [NREQ*XLEN-1:0] req_wd;
    logic                 rf_wen;
    logic [AW-1:0]        rf_wa;
    logic [XLEN-1:0]      rf_wd;
    logic                 sb_set;
    logic [AW-1:0]        sb_set_addr;
    logic [AW-1:0]        q_ra1;
    logic [AW-1:0]        q_ra2;
    logic                 q_busy1;
    logic                 q_busy2;
`ifdef RV32_WB_BYPASS_EN
    logic                 q_fwd1;
    logic                 q_fwd2;
    logic [XLEN-1:0]      q_fwd_data;
`endif

    rv32_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_wa      (req_wa),
        .req_wd      (req_wd),
        .rf_wen      (rf_wen),
        .rf_wa       (rf_wa),
        .rf_wd       (rf_wd),
        .sb_set      (sb_set),
        .sb_set_addr (sb_set_addr),
        .q_ra1       (q_ra1),
        .q_ra2       (q_ra2),
        .q_busy1     (q_busy1),
        .q_busy2     (q_busy2)
`ifdef RV32_WB_BYPASS_EN
        ,
        .q_fwd1      (q_fwd1),
        .q_fwd2      (q_fwd2),
        .q_fwd_data  (q_fwd_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic            wen;
        logic [AW-1:0]   wa;
        logic [XLEN-1:0] wd;
    } wr_t;

    wr_t             exp_q[$];
    int              checks;
    int              failures;
    int              mptr;
    logic [31:0]     msb;
    logic            m_wen;
    logic [AW-1:0]   m_wa;
    logic [XLEN-1:0] m_wd;
    int              last_grant;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic fwd_model(input logic [AW-1:0] a);
        return m_wen && (m_wa == a) && (a != '0);
    endfunction

    function automatic logic busy_model(input logic [AW-1:0] a);
        logic b;
        b = (a == '0) ? 1'b0 : msb[a];
`ifdef RV32_WB_BYPASS_EN
        if (fwd_model(a)) b = 1'b0;
`endif
        return b;
    endfunction

    task automatic set_req(input int i, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd);
        req_wa[i*AW +: AW]     = wa;
        req_wd[i*XLEN +: XLEN] = wd;
    endtask

    task automatic model_reset();
        mptr  = 0;
        msb   = '0;
        m_wen = 1'b0;
        m_wa  = '0;
        m_wd  = '0;
        exp_q.delete();
    endtask

    // One cycle: called just after a falling edge, returns just after the next falling edge.
    task automatic tick();
        logic [NREQ-1:0] er;
        int              g;
        wr_t             e;
        wr_t             o;
        #1;
        er = '0;
        g  = -1;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (mptr + k) % NREQ;
            if (g < 0 && req_valid[i]) g = i;
        end
        if (g >= 0) er[g] = 1'b1;
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("q_busy1", 64'(q_busy1), 64'(busy_model(q_ra1)));
        chk("q_busy2", 64'(q_busy2), 64'(busy_model(q_ra2)));
`ifdef RV32_WB_BYPASS_EN
        chk("q_fwd1", 64'(q_fwd1), 64'(fwd_model(q_ra1)));
        chk("q_fwd2", 64'(q_fwd2), 64'(fwd_model(q_ra2)));
        if (fwd_model(q_ra1)) chk("q_fwd_data", 64'(q_fwd_data), 64'(m_wd));
`endif
        if (m_wen) msb[m_wa] = 1'b0;
        if (sb_set && sb_set_addr != '0) msb[sb_set_addr] = 1'b1;
        if (g >= 0) begin
            e.wa  = req_wa[g*AW +: AW];
            e.wd  = req_wd[g*XLEN +: XLEN];
            e.wen = (e.wa != '0);
            mptr  = (g + 1) % NREQ;
        end else begin
            e.wen = 1'b0;
            e.wa  = m_wa;
            e.wd  = m_wd;
        end
        last_grant = g;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            o = exp_q.pop_front();
            chk("rf_wen", 64'(rf_wen), 64'(o.wen));
            chk("rf_wa", 64'(rf_wa), 64'(o.wa));
            chk("rf_wd", 64'(rf_wd), 64'(o.wd));
            m_wen = o.wen;
            m_wa  = o.wa;
            m_wd  = o.wd;
        end
        @(negedge clk);
    endtask

    initial begin
        int rr_exp[6];
        checks      = 0;
        failures    = 0;
        rst_n       = 1'b0;
        req_valid   = '1;
        req_wa      = '0;
        req_wd      = '0;
        sb_set      = 1'b0;
        sb_set_addr = '0;
        q_ra1       = '0;
        q_ra2       = '0;
        model_reset();
        rr_exp = '{0, 1, 2, 0, 1, 2};

        #2;
        chk("rst_rf_wen", 64'(rf_wen), 64'd0);
        chk("rst_rf_wa", 64'(rf_wa), 64'd0);
        chk("rst_rf_wd", 64'(rf_wd), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        // All three requesters held valid: strict 0,1,2 rotation.
        set_req(0, 5'd1, 32'h1111_0000);
        set_req(1, 5'd2, 32'h2222_0000);
        set_req(2, 5'd3, 32'h3333_0000);
        req_valid = 3'b111;
        for (int n = 0; n < 6; n++) begin
            tick();
            chk("rr_order", 64'(last_grant), 64'(rr_exp[n]));
        end
        req_valid = '0;

        // Single requester; pointer is back at 0.
        set_req(1, 5'd7, 32'hDEAD_BEEF);
        req_valid = 3'b010;
        #1;
        chk("single_ready", 64'(req_ready), 64'b010);
        tick();
        req_valid = '0;
        chk("single_wen", 64'(rf_wen), 64'd1);
        chk("single_wd", 64'(rf_wd), 64'hDEAD_BEEF);
        tick();
        chk("single_wen_drop", 64'(rf_wen), 64'd0);

        // x0 write, plus an attempted scoreboard set of x0.
        set_req(0, 5'd0, 32'h0000_1234);
        req_valid   = 3'b001;
        sb_set      = 1'b1;
        sb_set_addr = 5'd0;
        q_ra1       = 5'd0;
        tick();
        chk("x0_wen", 64'(rf_wen), 64'd0);
        req_valid = '0;
        sb_set    = 1'b0;
        tick();
        chk("x0_busy", 64'(q_busy1), 64'd0);

        // Scoreboard set, then clear by a write to x5.
        q_ra1       = 5'd5;
        q_ra2       = 5'd7;
        sb_set      = 1'b1;
        sb_set_addr = 5'd5;
        tick();
        sb_set = 1'b0;
        set_req(2, 5'd5, 32'h5555_AAAA);
        req_valid = 3'b100;
        tick();
        req_valid = '0;
        tick();
        tick();
        chk("x5_cleared", 64'(q_busy1), 64'd0);

        // Same-edge set and clear of x5: set wins.
        sb_set = 1'b1;
        tick();
        sb_set    = 1'b0;
        req_valid = 3'b001;
        set_req(0, 5'd5, 32'h0BAD_F00D);
        tick();
        req_valid = '0;
        sb_set    = 1'b1;
        tick();
        sb_set = 1'b0;
        tick();
        chk("x5_set_wins", 64'(q_busy1), 64'd1);

        // Pending x9 written with a distinctive value; forwarding visible in bypass builds.
        q_ra1       = 5'd9;
        q_ra2       = 5'd9;
        sb_set      = 1'b1;
        sb_set_addr = 5'd9;
        tick();
        sb_set = 1'b0;
        set_req(1, 5'd9, 32'hCAFE_0001);
        req_valid = 3'b010;
        tick();
        req_valid = '0;
        tick();
        tick();

        // Reset mid-stream: a write in flight and x12 pending.
        q_ra1       = 5'd12;
        q_ra2       = 5'd5;
        set_req(2, 5'd12, 32'h1212_1212);
        req_valid   = 3'b100;
        sb_set      = 1'b1;
        sb_set_addr = 5'd12;
        tick();
        sb_set = 1'b0;
        chk("pre_rst_wen", 64'(rf_wen), 64'd1);
        chk("pre_rst_busy", 64'(q_busy2), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wen", 64'(rf_wen), 64'd0);
        chk("mid_rst_wa", 64'(rf_wa), 64'd0);
        chk("mid_rst_wd", 64'(rf_wd), 64'd0);
        chk("mid_rst_ready", 64'(req_ready), 64'd0);
        chk("mid_rst_busy1", 64'(q_busy1), 64'd0);
        chk("mid_rst_busy2", 64'(q_busy2), 64'd0);
        model_reset();
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv32_wb_arbiter.md
Name: rv32_wb_arbiter

Overview:
- Shares the single register-file write port (wen/wa/wd) among NREQ writeback requesters, e.g. ALU, load unit, CSR unit.
- Uses round-robin arbitration over a valid/ready handshake.
- Registers the granted write for one cycle before driving the register file.
- Keeps a busy scoreboard of registers with a pending writeback, so issue logic can detect RAW hazards on its two read addresses.

Parameters:
- NREQ, 3, number of writeback requesters (2..8).
- XLEN, 32, data width; matches XPR_LEN.
- AW, 5, register address width; matches REG_ADDR_WIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  requester i has a write pending.
- req_ready  out  NREQ  requester i's write is accepted this cycle.
- req_wa  in  NREQ*AW  destination of requester i, slice [i*AW +: AW].
- req_wd  in  NREQ*XLEN  data of requester i, slice [i*XLEN +: XLEN].
- rf_wen  out  1  register-file write enable.
- rf_wa  out  AW  register-file write address.
- rf_wd  out  XLEN  register-file write data.
- sb_set  in  1  issue stage marks register sb_set_addr as pending.
- sb_set_addr  in  AW  register to mark.
- q_ra1  in  AW  hazard query address 1.
- q_ra2  in  AW  hazard query address 2.
- q_busy1  out  1  q_ra1 has a pending write (combinational).
- q_busy2  out  1  q_ra2 has a pending write (combinational).

Behaviour:
- Reset (async, rst_n=0):
  - rf_wen=0, rf_wa=0, rf_wd=0.
  - Round-robin pointer = 0.
  - All scoreboard bits = 0.
  - req_ready=0 while in reset.
- Arbitration (combinational each cycle):
  - Search starts at the pointer and proceeds upward modulo NREQ.
  - The first i with req_valid[i]=1 gets req_ready[i]=1; all other bits are 0.
  - At most one ready bit is high. No valid requests gives all ready bits 0.
- Transfer:
  - Occurs when req_valid[i] & req_ready[i].
  - On that edge: rf_wa<=req_wa[i], rf_wd<=req_wd[i], rf_wen<=(req_wa[i]!=0).
  - With no transfer, rf_wen<=0; rf_wa/rf_wd hold their values.
  - Latency from accept to register-file write is exactly 1 cycle. Throughput is 1 write per cycle.
- Pointer update:
  - After a transfer from i, pointer <= (i+1) mod NREQ.
  - No transfer leaves the pointer unchanged.
  - Guarantees no starvation: a held request is granted within NREQ cycles.
- Requester rules:
  - req_wa/req_wd must stay stable while valid and not ready.
  - Valid must not drop before ready. The arbiter does not check this.
- Scoreboard, 2^AW bits:
  - Clear: when rf_wen=1, bit[rf_wa] clears at the next edge, i.e. the edge that performs the register-file write.
  - Set: sb_set=1 with sb_set_addr!=0 sets bit[sb_set_addr].
  - Set and clear of the same register on the same edge: set wins, since a newer instruction is now pending.
  - Writing a register whose bit is already 0 is legal and leaves it 0.
  - Bit 0 is hardwired to 0. q_busyN for address 0 is always 0.
  - q_busyN = bit[q_raN], combinational. Without the optional feature it includes the register being written this cycle.

Optional Feature:
- Macro: RV32_WB_BYPASS_EN.
- When defined:
  - Adds outputs q_fwd1 and q_fwd2 (1 bit each) and q_fwd_data (XLEN).
  - q_fwdN = rf_wen & (rf_wa==q_raN) & (q_raN!=0).
  - When q_fwdN=1, q_busyN is forced to 0 and q_fwd_data = rf_wd.
  - This lets issue consume the value in the same cycle it is written.
- When undefined:
  - None of these ports exist.
  - q_busyN behaves exactly as described in Behaviour.

Test Plan:
- Reset mid-stream: assert rst_n=0 while rf_wen=1 with the scoreboard nonzero -> all outputs and scoreboard bits are 0 immediately, before any clock edge.
- Single requester: req_valid=3'b010, wa=7, wd=0xDEADBEEF -> req_ready=3'b010 the same cycle; next cycle rf_wen=1, rf_wa=7, rf_wd=0xDEADBEEF; the cycle after, rf_wen=0.
- Round-robin: all three requesters held valid for 6 cycles -> grant order 0,1,2,0,1,2; each requester is granted once per 3 cycles.
- x0 write: requester writes wa=0, wd=0x1234 -> req_ready=1, rf_wen stays 0, q_busy for address 0 stays 0.
- Scoreboard: sb_set to x5 -> q_busy1=1 with q_ra1=5. Requester writes x5 -> q_busy1=1 during the rf_wen cycle, 0 after. Same-edge sb_set x5 with an rf_wen write to x5 -> x5 stays busy.
- Bypass build (RV32_WB_BYPASS_EN): pending x9, write 0xCAFE0001 -> during the rf_wen cycle q_busy1=0, q_fwd1=1, q_fwd_data=0xCAFE0001.
